// File: rtl/edge_uart_tx.sv
// Pixel FIFO plus 8N1 UART transmitter for the edge-detection output path.
// Buffers pi_data strobes and streams each byte back to the host on tx.
module edge_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 256,
  parameter int FRAME_PIX  = 9604
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [7:0]                    pi_data,
  input  logic                          pi_flag,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int BIT_CNT_MAX = CLK_FREQ / BAUD - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW =
    (BIT_CNT_MAX > 0) ? $clog2(BIT_CNT_MAX + 1) : 1;
  localparam int PW =
    (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      rd_data;
  logic [7:0]      shift;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [PW-1:0]   pix_cnt;
  logic            nempty;
  logic            full;
  logic            baud_end;
  logic            pop;
  logic            push;

  assign nempty   = (fifo_cnt != '0);
  assign full     = (fifo_cnt == CW'(FIFO_DEPTH));
  assign baud_end = (baud_cnt == BW'(BIT_CNT_MAX));
  assign rd_data  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign pop  = nempty &&
                ((state == IDLE) ||
                 ((state == STOP) && baud_end));
  assign push = pi_flag && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= pi_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - 1'b1;
      if (pi_flag && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift   <= rd_data;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end else begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pix_cnt == PW'(FRAME_PIX - 1)) begin
              pix_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
            // Chain straight into the next frame with no idle bit.
            if (pop) begin
              shift <= rd_data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/edge_uart_tx.md
Name: edge_uart_tx

Overview:
- Output end of the edge-detection pixel path: accepts the binarised pixel stream (pi_data/pi_flag strobes, one pixel per strobe, arbitrary gaps) and buffers it in an internal FIFO.
- Serialises each pixel as one 8N1 UART frame on tx, so the processed image returns to the host over the same serial link that supplied it.
- Counts transmitted pixels per image and flags buffer overflow.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: UART bit rate. BIT_CNT_MAX = CLK_FREQ/BAUD - 1 (5207 at defaults).
- FIFO_DEPTH, 256: pixel buffer depth; must be a power of two. Implemented as an internal register array (no vendor IP).
- FRAME_PIX, 9604: pixels per processed image (98x98).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- pi_data  in  8  pixel value (0x00 black / 0xFF white; any byte accepted).
- pi_flag  in  1  pixel strobe; 1-cycle pulse per valid pi_data.
- tx  out  1  UART serial output, idle high.
- tx_busy  out  1  high while a UART frame (start..stop) is in progress.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- frame_done  out  1  1-cycle pulse when the FRAME_PIX-th pixel's stop bit completes.

Behaviour:
- Reset values (asynchronous, immediate): tx=1, tx_busy=0, fifo_cnt=0, overflow=0, frame_done=0. FSM in IDLE, all counters 0. Asserting reset mid-frame aborts the frame; tx returns high at once.
- FIFO write: pi_flag=1 and not full -> store pi_data at wr_ptr, wr_ptr+1 (wraps modulo FIFO_DEPTH).
- Overflow: pi_flag=1 while full (fifo_cnt==FIFO_DEPTH) and no pop in the same cycle -> pixel dropped, overflow<=1 until reset.
- Simultaneous push and pop: both happen; fifo_cnt is unchanged.
- Push and pop on a full FIFO: the pop frees the slot, the write is accepted, and overflow is not set.
- Pop on an empty FIFO never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_cnt!=0, pop one byte into shift register, tx<=0, tx_busy<=1, go START. Otherwise tx=1.
  - START: hold tx=0 for BIT_CNT_MAX+1 cycles, then go DATA with tx<=shift[0].
  - DATA: 8 bits LSB first, each BIT_CNT_MAX+1 cycles. bit_idx counts 0..7. After bit 7, tx<=1 and go STOP.
  - STOP: hold tx=1 for BIT_CNT_MAX+1 cycles, then increment pix_cnt.
    - If FIFO is non-empty, pop immediately and re-enter START on the same edge. Back-to-back frames have no idle gap; tx_busy stays 1.
    - Otherwise go IDLE with tx_busy<=0.
- Baud counter: runs 0..BIT_CNT_MAX; cleared on every state entry.
- Latency: pi_flag sampled at edge k into an empty FIFO with FSM IDLE -> write at edge k, pop at edge k+1, tx low from edge k+1.
- Frame length: exactly 10*(BIT_CNT_MAX+1) cycles per pixel.
- tx is driven from a register; no combinational path from pi_flag.
- pix_cnt: 0..FRAME_PIX-1. On completing the stop bit with pix_cnt==FRAME_PIX-1: frame_done pulses 1 cycle and pix_cnt wraps to 0. Dropped pixels are not counted.
- Steady-state check: at defaults the upstream pixel rate must not exceed the baud rate / 10. The FIFO absorbs bursts only.

Test Plan (bench uses CLK_FREQ=10, BAUD=1 -> 10 cycles/bit, FIFO_DEPTH=4, FRAME_PIX=3):
- Reset, then hold idle 50 cycles -> tx=1, tx_busy=0, fifo_cnt=0, overflow=0.
- Single pi_data=0xA5 strobe at edge k -> tx low from k+1 for 10 cycles. Data bits 1,0,1,0,0,1,0,1 each 10 cycles, then stop high 10 cycles. tx_busy falls at edge k+101.
- Burst of 3 consecutive strobes 0x00,0xFF,0x0C -> three back-to-back frames with no idle gap. frame_done pulses once, exactly at the end of the third stop bit. pix_cnt returns to 0.
- Burst of 6 strobes while the first frame is in progress -> after edge k+1 pops 1 byte, the FIFO holds 4 and the remaining write is dropped. overflow=1 and stays 1 for the rest of the test. Exactly 5 frames are transmitted.
- With FIFO full, issue a strobe on the exact cycle of a STOP->START pop -> byte accepted, fifo_cnt stays 4, overflow stays 0.
- Assert sys_rst mid-DATA of frame 0x3C -> tx=1 and tx_busy=0 asynchronously. After release the FIFO is empty and no residual frame is sent.
